// File: rtl/video_timing_gen_if.sv
// Register bus and raster outputs of video_timing_gen.
//   master : register-file client (drives address/data_in/wr, observes everything else)
//   slave  : the timing generator itself
//   address/data_in/wr/data_out : 3-bit register select, 16-bit write data, write strobe,
//                                 16-bit read data (decoded from the previous cycle's address)
//   hs/vs/de, hcount/vcount, x/y, h_tick/v_tick, irq_hsync/irq_vsync/irq_line : raster outputs
interface video_timing_gen_if #(
    parameter int CNT_BITS = 10
);
    logic [2:0]          address;
    logic [15:0]         data_in;
    logic [15:0]         data_out;
    logic                wr;
    logic                hs;
    logic                vs;
    logic                de;
    logic [CNT_BITS-1:0] hcount;
    logic [CNT_BITS-1:0] vcount;
    logic [CNT_BITS-1:0] x;
    logic [CNT_BITS-1:0] y;
    logic                h_tick;
    logic                v_tick;
    logic                irq_hsync;
    logic                irq_vsync;
    logic                irq_line;

    modport master (
        output address, data_in, wr,
        input  data_out, hs, vs, de, hcount, vcount, x, y,
               h_tick, v_tick, irq_hsync, irq_vsync, irq_line
    );

    modport slave (
        input  address, data_in, wr,
        output data_out, hs, vs, de, hcount, vcount, x, y,
               h_tick, v_tick, irq_hsync, irq_vsync, irq_line
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: H/V counters, sync/DE, scaled pixel coordinates,
// line/frame ticks and a programmable line-compare interrupt. MODE writes go to a shadow
// register that becomes active only on the frame-start clock (hcount==0 && vcount==0).
// Ports:
//   i_clk : pixel clock
//   i_rst : asynchronous reset, active high
//   bus   : video_timing_gen_if.slave (register bus + raster outputs)
// Register map: 0 MODE (shadow, RW), 1 LINE_CMP (RW), 2 FRAME_CNT (RO), 3 Y (RO),
//               4 STATUS (W1C: [0] line hit, [1] vsync seen), 5..7 read as 0.
module video_timing_gen #(
    parameter int CNT_BITS  = 10,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int FCNT_BITS = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    video_timing_gen_if.slave   bus
);
    typedef logic [CNT_BITS-1:0] cnt_t;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST   = cnt_t'(H_TOT - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOT - 1);
    localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_BEG_C = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END_C = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_BEG_C = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END_C = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t                 r_hcount;
    cnt_t                 r_vcount;
    logic [FCNT_BITS-1:0] r_frame_cnt;
    logic [4:0]           r_mode_shadow;
    logic [4:0]           r_mode;
    cnt_t                 r_line_cmp;
    logic [1:0]           r_status;
    logic [2:0]           r_addr;
    logic                 r_h_tick;
    logic                 r_v_tick;

    logic       w_frame_start;
    logic       w_hs_win;
    logic       w_vs_win;
    logic       w_hs_first;
    logic       w_vs_first;
    logic       w_line_hit;
    logic       w_wr_mode;
    logic       w_wr_cmp;
    logic       w_wr_status;
    logic [1:0] w_status_clr;
    logic [1:0] w_shift;
    cnt_t       w_y;

    assign w_frame_start = (r_hcount == '0) && (r_vcount == '0);
    assign w_hs_win      = (r_hcount >= HS_BEG_C) && (r_hcount < HS_END_C);
    assign w_vs_win      = (r_vcount >= VS_BEG_C) && (r_vcount < VS_END_C);
    assign w_hs_first    = (r_hcount == HS_BEG_C);
    assign w_vs_first    = (r_hcount == '0) && (r_vcount == VS_BEG_C);
    // vcount never reaches V_TOT, so a LINE_CMP at or beyond it simply never matches.
    assign w_line_hit    = r_mode[4] && (r_hcount == '0) && (r_vcount == r_line_cmp);

    assign w_wr_mode     = bus.wr && (bus.address == 3'd0);
    assign w_wr_cmp      = bus.wr && (bus.address == 3'd1);
    assign w_wr_status   = bus.wr && (bus.address == 3'd4);
    assign w_status_clr  = w_wr_status ? bus.data_in[1:0] : 2'b00;

    // Scale code 3 is reserved and behaves as 1x.
    always_comb begin
        w_shift = 2'd0;
        case (r_mode[1:0])
            2'd1:    w_shift = 2'd1;
            2'd2:    w_shift = 2'd2;
            default: w_shift = 2'd0;
        endcase
    end

    assign w_y = r_vcount >> w_shift;

    // Raster counters and frame counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hcount    <= '0;
            r_vcount    <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (r_hcount == H_LAST) begin
                r_hcount <= '0;
                r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
            if (w_frame_start)
                r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // Register file. The active MODE samples the shadow before this clock's write lands,
    // so a write on the frame-start clock is picked up one frame later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode_shadow <= '0;
            r_mode        <= '0;
            r_line_cmp    <= '0;
            r_status      <= '0;
            r_addr        <= '0;
        end else begin
            r_addr <= bus.address;
            if (w_wr_mode)
                r_mode_shadow <= bus.data_in[4:0];
            if (w_frame_start)
                r_mode <= r_mode_shadow;
            if (w_wr_cmp)
                r_line_cmp <= bus.data_in[CNT_BITS-1:0];
            // Hardware set beats a simultaneous write-one-to-clear.
            r_status <= (r_status & ~w_status_clr) | {w_vs_first, w_line_hit};
        end
    end

    // Line/frame ticks, one clock after the corresponding counter position.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_tick <= 1'b0;
            r_v_tick <= 1'b0;
        end else begin
            r_h_tick <= (r_hcount == '0);
            r_v_tick <= w_frame_start;
        end
    end

    // Read data decodes the address captured on the previous clock.
    always_comb begin
        bus.data_out = '0;
        case (r_addr)
            3'd0:    bus.data_out = 16'(r_mode_shadow);
            3'd1:    bus.data_out = 16'(r_line_cmp);
            3'd2:    bus.data_out = 16'(r_frame_cnt);
            3'd3:    bus.data_out = 16'(w_y);
            3'd4:    bus.data_out = 16'(r_status);
            default: bus.data_out = '0;
        endcase
    end

    // Sync windows are inverted unless the polarity bit selects active-high.
    assign bus.hs        = w_hs_win ^ ~r_mode[2];
    assign bus.vs        = w_vs_win ^ ~r_mode[3];
    assign bus.de        = (r_hcount < H_ACT_C) && (r_vcount < V_ACT_C);
    assign bus.hcount    = r_hcount;
    assign bus.vcount    = r_vcount;
    assign bus.x         = r_hcount >> w_shift;
    assign bus.y         = w_y;
    assign bus.h_tick    = r_h_tick;
    assign bus.v_tick    = r_v_tick;
    assign bus.irq_hsync = w_hs_first;
    assign bus.irq_vsync = w_vs_first;
    assign bus.irq_line  = r_status[0] & r_mode[4];
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. u_s uses a shrunken raster (32 clks x 20 lines) so whole
// frames are cheap; u_d runs default timing and u_o the 320/8/48/24 horizontal override,
// both observed over their first lines only. Register reads are scored through a queue.
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_req = 1'b0;
    logic rd_d;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    video_timing_gen_if #(.CNT_BITS(10)) s_if ();
    video_timing_gen_if #(.CNT_BITS(10)) d_if ();
    video_timing_gen_if #(.CNT_BITS(10)) o_if ();

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) u_s (.i_clk(clk), .i_rst(rst), .bus(s_if.slave));

    video_timing_gen u_d (.i_clk(clk), .i_rst(rst), .bus(d_if.slave));

    video_timing_gen #(
        .H_ACTIVE(320), .H_FP(8), .H_SYNC(48), .H_BP(24)
    ) u_o (.i_clk(clk), .i_rst(rst), .bus(o_if.slave));

    typedef struct {
        string       nm;
        logic [15:0] val;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Read-data monitor: one cycle after a read is issued, data_out must match the queue head.
    always @(posedge clk) rd_d <= rd_req;

    always @(negedge clk) begin
        if (rd_d) begin
            if (exp_q.size() == 0) begin
                chk("rd_queue_underrun", 1, 0);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                chk(e.nm, s_if.data_out, e.val);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        rd_req  = 1'b0;
        s_if.wr = 1'b0;
    endtask

    task automatic issue_rd(input logic [2:0] a, input logic [15:0] v, input string nm);
        rd_exp_t e;
        e.nm  = nm;
        e.val = v;
        exp_q.push_back(e);
        s_if.address = a;
        rd_req       = 1'b1;
    endtask

    task automatic issue_wr(input logic [2:0] a, input logic [15:0] d);
        s_if.address = a;
        s_if.data_in = d;
        s_if.wr      = 1'b1;
    endtask

    // Advance to the negedge where u_s shows (h,v); always moves at least one clock.
    task automatic goto(input int h, input int v);
        int n = 0;
        step();
        while (!(s_if.hcount == h && s_if.vcount == v) && n < 2000) begin
            step();
            n++;
        end
        chk("goto_reached", (n < 2000), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_rast, s_sync, s_de, s_xy, s_ht, s_vt, s_ih, s_iv, s_vslow;
        int d_bad, d_hslow, o_bad, o_hslow, cnt, bad;
        s_rast = 0; s_sync = 0; s_de = 0; s_xy = 0; s_ht = 0; s_vt = 0; s_ih = 0; s_iv = 0;
        s_vslow = 0; d_bad = 0; d_hslow = 0; o_bad = 0; o_hslow = 0;

        s_if.address = '0; s_if.data_in = '0; s_if.wr = 1'b0;
        d_if.address = '0; d_if.data_in = '0; d_if.wr = 1'b0;
        o_if.address = '0; o_if.data_in = '0; o_if.wr = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_hcount", s_if.hcount, 0);
        chk("rst_vcount", s_if.vcount, 0);
        chk("rst_ticks", {s_if.h_tick, s_if.v_tick}, 0);
        chk("rst_irqs", {s_if.irq_hsync, s_if.irq_vsync, s_if.irq_line}, 0);
        chk("rst_data_out", s_if.data_out, 0);
        chk("rst_d_hcount", d_if.hcount, 0);

        // Free run: sample i is the negedge i clocks after release.
        rst = 1'b0;
        for (int i = 0; i < 1600; i++) begin
            int eh, ev, dh, dv, oh, ov;
            if (i > 0) step();
            eh = i % 32; ev = (i / 32) % 20;
            dh = i % 800; dv = i / 800;
            oh = i % 400; ov = i / 400;
            if (s_if.hcount != eh || s_if.vcount != ev) s_rast++;
            if (s_if.hs != !(eh >= 20 && eh < 26) || s_if.vs != !(ev >= 14 && ev < 16)) s_sync++;
            if (s_if.de != (eh < 16 && ev < 12)) s_de++;
            if (s_if.x != eh || s_if.y != ev) s_xy++;
            if (s_if.h_tick) s_ht++;
            if (s_if.v_tick) s_vt++;
            if (s_if.irq_hsync) s_ih++;
            if (s_if.irq_vsync) s_iv++;
            if (!s_if.vs) s_vslow++;
            if (d_if.hcount != dh || d_if.vcount != dv ||
                d_if.hs != !(dh >= 656 && dh < 752) || d_if.de != (dh < 640)) d_bad++;
            if (!d_if.hs) d_hslow++;
            if (o_if.hcount != oh || o_if.vcount != ov ||
                o_if.hs != !(oh >= 328 && oh < 376)) o_bad++;
            if (!o_if.hs) o_hslow++;
            // Exactly one frame elapsed: counter bumped only on the first (0,0) clock.
            if (i == 639) issue_rd(3'd2, 16'd1, "frame_cnt_one_frame");
        end
        chk("s_raster_errs", s_rast, 0);
        chk("s_sync_errs", s_sync, 0);
        chk("s_de_errs", s_de, 0);
        chk("s_xy_errs", s_xy, 0);
        chk("s_h_tick_count", s_ht, 50);   // 50 line starts in 1600 clks
        chk("s_v_tick_count", s_vt, 3);    // frame starts at clks 0, 640, 1280
        chk("s_irq_hsync_count", s_ih, 50);
        chk("s_irq_vsync_count", s_iv, 2);
        chk("s_vs_low_clks", s_vslow, 128); // 2 sync lines x 32 clks x 2 frames
        chk("d_raster_errs", d_bad, 0);
        chk("d_hs_low_clks", d_hslow, 192); // 656..751 on two lines
        chk("o_raster_errs", o_bad, 0);
        chk("o_hs_low_clks", o_hslow, 192); // 328..375 on four lines

        // Mid-frame MODE write waits for frame start
        goto(0, 5);
        issue_wr(3'd0, 16'd1);
        step();
        issue_rd(3'd0, 16'd1, "mode_shadow_readback");
        goto(10, 6);
        chk("x_before_frame_start", s_if.x, 10);
        goto(0, 0);
        goto(10, 0);
        chk("x_2x", s_if.x, 5);
        goto(10, 7);
        chk("y_2x", s_if.y, 3);
        issue_rd(3'd3, 16'd3, "y_register");

        // Write on the frame-start clock applies one frame later
        goto(0, 0);
        issue_wr(3'd0, 16'd2);
        goto(12, 1);
        chk("x_sameclk_still_2x", s_if.x, 6);
        issue_rd(3'd0, 16'd2, "mode_readback_4x");
        goto(0, 0);
        goto(12, 1);
        chk("x_4x", s_if.x, 3);
        goto(0, 2);
        issue_wr(3'd0, 16'd3);
        goto(0, 0);
        goto(12, 1);
        chk("x_scale3_is_1x", s_if.x, 12);

        // Active-high sync polarity
        issue_wr(3'd0, 16'h000C);
        goto(0, 0);
        goto(19, 1);
        chk("hs_pos_before", s_if.hs, 0);
        step();
        chk("hs_pos_first", s_if.hs, 1);
        goto(25, 1);
        chk("hs_pos_last", s_if.hs, 1);
        step();
        chk("hs_pos_after", s_if.hs, 0);
        goto(0, 13);
        chk("vs_pos_before", s_if.vs, 0);
        goto(0, 14);
        chk("vs_pos_first", s_if.vs, 1);
        chk("irq_vsync_pulse", s_if.irq_vsync, 1);
        goto(0, 15);
        chk("vs_pos_last", s_if.vs, 1);
        goto(0, 16);
        chk("vs_pos_after", s_if.vs, 0);

        // Line compare interrupt
        issue_wr(3'd1, 16'd8);
        step();
        issue_rd(3'd1, 16'd8, "line_cmp_readback");
        step();
        issue_wr(3'd0, 16'h0010);
        step();
        issue_wr(3'd4, 16'd3);
        goto(0, 0);
        goto(0, 8);
        chk("irq_line_before_hit", s_if.irq_line, 0);
        step();
        chk("irq_line_rise", s_if.irq_line, 1);
        issue_rd(3'd4, 16'd1, "status_line_hit");
        goto(0, 12);
        chk("irq_line_held", s_if.irq_line, 1);
        issue_wr(3'd4, 16'd1);
        step();
        chk("irq_line_w1c", s_if.irq_line, 0);
        issue_rd(3'd4, 16'd0, "status_cleared");
        goto(0, 8);
        issue_wr(3'd4, 16'd1);
        step();
        chk("irq_line_set_wins", s_if.irq_line, 1);
        issue_rd(3'd4, 16'd3, "status_hit_and_vsync");
        goto(0, 14);
        issue_wr(3'd4, 16'd3);
        step();
        chk("irq_line_cleared2", s_if.irq_line, 0);
        issue_rd(3'd4, 16'd2, "status_vsync_set_wins");
        step();
        issue_wr(3'd1, 16'd20);
        cnt = 0;
        for (int i = 0; i < 700; i++) begin
            step();
            if (s_if.irq_line) cnt++;
        end
        chk("line_cmp_ge_vtot_no_hit", cnt, 0);

        // Reset mid-frame
        goto(0, 10);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (s_if.hcount != 0 || s_if.vcount != 0 || s_if.h_tick || s_if.v_tick ||
                s_if.irq_hsync || s_if.irq_vsync || s_if.irq_line) bad++;
        end
        chk("reset_midframe_quiet", bad, 0);
        chk("reset_midframe_data_out", s_if.data_out, 0);
        rst = 1'b0;
        // Cleared counter bumps once on the first post-reset (0,0) clock.
        issue_rd(3'd2, 16'd1, "frame_cnt_after_reset");
        step();
        issue_rd(3'd0, 16'd0, "mode_after_reset");
        goto(10, 1);
        chk("x_after_reset_1x", s_if.x, 10);
        goto(20, 1);
        chk("hs_after_reset_low", s_if.hs, 0);

        repeat (3) step();
        chk("rd_queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
